// File: rtl/edge_train_generator.sv
// edge_train_generator
// Emits a burst of toggles on a single line, one toggle per event, with a
// programmable idle gap between consecutive toggles. Bursts are requested
// over a valid/ready handshake; a one-cycle done pulse marks completion.
// The receiving side is expected to recover one pulse per edge with a
// both-edges detector, so only the number and spacing of edges matter,
// not the absolute level of the line.

module edge_train_generator #(
    parameter int   CNT_W      = 8,
    parameter int   GAP_W      = 8,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [GAP_W-1:0] req_gap,
    output logic             data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_reg,   state_next;
    logic [CNT_W-1:0]   remain_reg,  remain_next;   // toggles still to emit
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;  // idle cycles left before next toggle
    logic [GAP_W-1:0]   gap_len_reg, gap_len_next;  // reload value for gap_cnt
    logic               data_reg,    data_next;
    logic               busy_reg,    busy_next;
    logic               done_reg,    done_next;

    logic               accept;

    assign accept = req_valid & req_ready;

    // State and datapath registers; reset abandons any burst without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            remain_reg  <= '0;
            gap_cnt_reg <= '0;
            gap_len_reg <= '0;
            data_reg    <= INIT_LEVEL;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            remain_reg  <= remain_next;
            gap_cnt_reg <= gap_cnt_next;
            gap_len_reg <= gap_len_next;
            data_reg    <= data_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Next-state and counter logic. The return to IDLE is folded so that it
    // happens on the edge right after the last toggle regardless of the gap:
    // once remain hits zero in RUN, no further gap is waited out.
    always_comb begin
        state_next   = state_reg;
        remain_next  = remain_reg;
        gap_cnt_next = gap_cnt_reg;
        gap_len_next = gap_len_reg;
        data_next    = data_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    gap_len_next = req_gap;
                    if (req_count == '0) begin
                        // Empty burst: nothing to emit, complete immediately.
                        remain_next  = '0;
                        gap_cnt_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        // First toggle goes out on the accepting edge.
                        state_next   = ST_RUN;
                        data_next    = ~data_reg;
                        remain_next  = req_count - CNT_W'(1);
                        gap_cnt_next = req_gap;
                    end
                end
            end

            ST_RUN: begin
                if (remain_reg == '0) begin
                    state_next   = ST_IDLE;
                    gap_cnt_next = '0;
                    done_next    = 1'b1;
                end else if (gap_cnt_reg != '0) begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end else begin
                    data_next    = ~data_reg;
                    remain_next  = remain_reg - CNT_W'(1);
                    gap_cnt_next = gap_len_reg;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_RUN);
    end

    // Handshake output: ready only while idle and not being reset.
    always_comb begin
        req_ready = (state_reg == ST_IDLE) && !reset;
    end

    assign data_out = data_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_edge_train_generator.sv
// Testbench for edge_train_generator: directed scenarios followed by random
// traffic, all checked every cycle against a timeline model that derives the
// expected line level, busy and done purely from the accept edge, count and
// gap of the most recent burst.

module tb_edge_train_generator;

    localparam int   CNT_W = 8;
    localparam int   GAP_W = 8;
    localparam logic INIT  = 1'b0;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [CNT_W-1:0] req_count = '0;
    logic [GAP_W-1:0] req_gap = '0;
    logic             data_out;
    logic             busy;
    logic             done;

    edge_train_generator #(
        .CNT_W      (CNT_W),
        .GAP_W      (GAP_W),
        .INIT_LEVEL (INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_count (req_count),
        .req_gap   (req_gap),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one burst described by its accept edge index and params.
    int   t = 0;          // index of the next rising edge
    logic base_level = INIT;
    bit   have_burst = 1'b0;
    int   b_e, b_n, b_g, b_last;
    logic exp_level = INIT;
    logic exp_busy  = 1'b0;
    logic exp_done  = 1'b0;
    int   n_accepts = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", tag, t, got, want);
        end
    endtask

    // Expected outputs in the cycle following edge idx.
    function automatic void eval(input int idx);
        int kv;
        if (!have_burst) begin
            exp_level = base_level;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
        end else if (b_n == 0) begin
            exp_level = base_level;
            exp_busy  = 1'b0;
            exp_done  = (idx == b_e);
        end else begin
            kv = (idx - b_e) / (b_g + 1) + 1;
            if (kv > b_n) kv = b_n;
            exp_level = base_level ^ kv[0];
            exp_busy  = (idx <= b_last);
            exp_done  = (idx == b_last + 1);
        end
    endfunction

    // One clock: update the model at the edge, then compare at the falling edge.
    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = req_valid && !reset && !exp_busy;
        if (reset) begin
            have_burst = 1'b0;
            base_level = INIT;
        end else if (acc) begin
            if (have_burst) base_level = base_level ^ b_n[0];
            have_burst = 1'b1;
            b_e    = t;
            b_n    = int'(req_count);
            b_g    = int'(req_gap);
            b_last = b_e + (b_n - 1) * (b_g + 1);
            n_accepts++;
        end
        eval(t);
        t++;
        @(negedge clk);
        check("data_out",  {31'd0, data_out},  {31'd0, exp_level});
        check("busy",      {31'd0, busy},      {31'd0, exp_busy});
        check("done",      {31'd0, done},      {31'd0, exp_done});
        check("req_ready", {31'd0, req_ready}, {31'd0, !reset && !exp_busy});
        $display("edge=%0d rst=%0b vld=%0b cnt=%0d gap=%0d | line=%0b busy=%0b done=%0b rdy=%0b",
                 t - 1, reset, req_valid, req_count, req_gap, data_out, busy, done, req_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int cnt, input int gap);
        req_valid = 1'b1;
        req_count = CNT_W'(cnt);
        req_gap   = GAP_W'(gap);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int edges;
        logic prev;

        // Reset state.
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(6);

        // count=1, gap=0.
        send(1, 0);
        idle(6);

        // count=3, gap=2, also counting edges on the line.
        edges = 0;
        prev  = data_out;
        send(3, 2);
        for (int i = 0; i < 10; i++) begin
            if (data_out !== prev) edges++;
            prev = data_out;
            tick();
        end
        check("edges_cnt3", edges, 3);

        // count=4, gap=0: line ends back where it started.
        send(4, 0);
        idle(6);
        check("level_after_cnt4", {31'd0, data_out}, {31'd0, base_level});

        // count=0: immediate done, no busy.
        send(0, 5);
        idle(3);

        // Back-to-back with valid held high through the burst.
        req_valid = 1'b1;
        req_count = 8'd2;
        req_gap   = 8'd1;
        tick();
        req_count = 8'd1;
        req_gap   = 8'd0;
        idle(6);
        req_valid = 1'b0;
        idle(3);

        // Reset after the 4th toggle of a count=10, gap=3 burst.
        send(10, 3);
        idle(12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(2);
        send(2, 0);
        idle(5);

        // Boundary widths.
        send(255, 0);
        idle(258);
        send(2, 255);
        idle(260);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_count = CNT_W'($urandom_range(0, 6));
            req_gap   = GAP_W'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        idle(40);

        check("any_accepts", {31'd0, n_accepts > 20}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
